// File: rtl/sargantana_icache_pkg.sv
// sargantana_icache_pkg: shared icache geometry, FSM state and vector types
package sargantana_icache_pkg;
  localparam int ICACHE_N_WAY = 4;
  localparam int TAG_WIDHT = 20;
  localparam int TAG_ADDR_WIDHT = 6;
  localparam int N_SETS = 2**TAG_ADDR_WIDHT;
  typedef enum logic [1:0] {INIT, IDLE, FLUSH} itag_ctrl_state_t;
  typedef logic [ICACHE_N_WAY-1:0] way_t;
  typedef logic [TAG_WIDHT-1:0] tag_t;
  typedef logic [TAG_ADDR_WIDHT-1:0] set_t;
endpackage

// File: rtl/sargantana_itag_ctrl_if.sv
// sargantana_itag_ctrl_if: requester and tag-memory signals of the tag controller
interface sargantana_itag_ctrl_if;
  import sargantana_icache_pkg::*;
  logic lookup_valid_i, lookup_ready_o;
  set_t lookup_addr_i;
  tag_t lookup_tag_i;
  logic rsp_valid_o, rsp_hit_o;
  way_t rsp_way_o;
  logic refill_valid_i, refill_ready_o;
  set_t refill_addr_i;
  tag_t refill_tag_i;
  way_t refill_way_i;
  logic flush_i, flush_done_o, busy_o;
  way_t mem_req_o;
  logic mem_we_o, mem_vbit_o;
  tag_t mem_data_o;
  set_t mem_addr_o;
  logic [ICACHE_N_WAY*TAG_WIDHT-1:0] mem_tag_way_i;
  way_t mem_vbit_i;
  modport slave (
    input lookup_valid_i, lookup_addr_i, lookup_tag_i, refill_valid_i, refill_addr_i,
          refill_tag_i, refill_way_i, flush_i, mem_tag_way_i, mem_vbit_i,
    output lookup_ready_o, rsp_valid_o, rsp_hit_o, rsp_way_o, refill_ready_o,
           flush_done_o, busy_o, mem_req_o, mem_we_o, mem_vbit_o, mem_data_o, mem_addr_o
  );
  modport master (
    output lookup_valid_i, lookup_addr_i, lookup_tag_i, refill_valid_i, refill_addr_i,
           refill_tag_i, refill_way_i, flush_i, mem_tag_way_i, mem_vbit_i,
    input lookup_ready_o, rsp_valid_o, rsp_hit_o, rsp_way_o, refill_ready_o,
          flush_done_o, busy_o, mem_req_o, mem_we_o, mem_vbit_o, mem_data_o, mem_addr_o
  );
endinterface

// File: rtl/sargantana_itag_cmp.sv
// sargantana_itag_cmp: per-way tag compare giving one-hot hit way and hit flag
module sargantana_itag_cmp import sargantana_icache_pkg::*; (
  input  logic [ICACHE_N_WAY*TAG_WIDHT-1:0] tag_way,
  input  way_t vbit,
  input  tag_t tag,
  output way_t way,
  output logic hit
);
  for (genvar w = 0; w < ICACHE_N_WAY; w++) begin : g_way
    assign way[w] = vbit[w] && tag_way[w*TAG_WIDHT +: TAG_WIDHT] == tag;
  end
  assign hit = |way;
endmodule

// File: rtl/sargantana_itag_ctrl.sv
// sargantana_itag_ctrl: arbitrates the tag-memory port between sweeps, refills and lookups
module sargantana_itag_ctrl import sargantana_icache_pkg::*; (
  input logic clk_i,
  input logic rst_i,
  sargantana_itag_ctrl_if.slave bus
);
  itag_ctrl_state_t state, state_nx;
  set_t cnt;
  logic pending, rsp_q, idle, last, sweep, refill_take, lookup_take, hit;
  tag_t tag_q;
  way_t hit_way;
  assign idle = state == IDLE;
  assign last = !idle && cnt == '1;
  assign sweep = !idle && !rst_i;
  assign refill_take = idle && !bus.flush_i && bus.refill_valid_i;
  assign lookup_take = idle && !bus.flush_i && !bus.refill_valid_i && bus.lookup_valid_i;
  // state, sweep counter and flush-pending flag; a flush seen mid-sweep is replayed at its end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= INIT;
      cnt <= '0;
      pending <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= idle ? '0 : cnt + 1'b1;
      pending <= !idle && !last && (pending || bus.flush_i);
    end
  // next state: flush wins in IDLE, a finished sweep chains into another if flush is pending
  always_comb
    state_nx = idle ? (bus.flush_i ? FLUSH : IDLE) :
               last ? ((pending || bus.flush_i) ? FLUSH : IDLE) : state;
  // lookup tag and response-valid registers, aligned with the 1-cycle memory read
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rsp_q <= 1'b0;
      tag_q <= '0;
    end else begin
      rsp_q <= lookup_take;
      if (lookup_take) tag_q <= bus.lookup_tag_i;
    end
  sargantana_itag_cmp cmp (
    .tag_way(bus.mem_tag_way_i),
    .vbit(bus.mem_vbit_i),
    .tag(tag_q),
    .way(hit_way),
    .hit(hit)
  );
  // outputs: memory port mux by priority sweep > refill > lookup, plus handshakes and response
  always_comb begin
    bus.lookup_ready_o = idle && !bus.flush_i && !bus.refill_valid_i;
    bus.refill_ready_o = refill_take;
    bus.flush_done_o = last;
    bus.busy_o = !idle || pending;
    bus.mem_req_o = sweep ? '1 : refill_take ? bus.refill_way_i : lookup_take ? '1 : '0;
    bus.mem_we_o = sweep || refill_take;
    bus.mem_vbit_o = refill_take;
    bus.mem_data_o = refill_take ? bus.refill_tag_i : '0;
    bus.mem_addr_o = sweep ? cnt : refill_take ? bus.refill_addr_i : lookup_take ? bus.lookup_addr_i : '0;
    bus.rsp_valid_o = rsp_q;
    bus.rsp_hit_o = rsp_q && hit;
    bus.rsp_way_o = rsp_q ? hit_way : '0;
  end
endmodule
